// File: rtl/jk_bank_pkg.sv
// Shared types and constants for the JK bank driver: FSM states, per-bit {j,k}
// excitation codes and the excitation rule used by jk_excite.
package jk_bank_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        CHECK = 2'd2
    } state_t;

    // Per-bit {j,k} codes.
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_CLR  = 2'b01;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // Single-bit excitation; don't-care entries resolve to 0 unless toggling is enabled.
    function automatic logic [1:0] excite_bit(input logic q, input logic t, input logic tgl_en);
        if (q == t)
            return JK_HOLD;
        else if (tgl_en)
            return JK_TGL;
        else if (t)
            return JK_SET;
        else
            return JK_CLR;
    endfunction

endpackage

// File: rtl/jk_bank_driver_if.sv
// Target-word valid/ready handshake into the JK bank driver.
interface jk_bank_driver_if
    import jk_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             tgt_valid;
    logic             tgt_ready;
    logic [WIDTH-1:0] tgt_data;

    modport master (output tgt_valid, output tgt_data, input  tgt_ready);
    modport slave  (input  tgt_valid, input  tgt_data, output tgt_ready);
endinterface

// File: rtl/jk_excite.sv
// Combinational WIDTH-wide JK excitation from present q to target.
// Define JK_BANK_DRV_TOGGLE_EN to drive changing bits with J=K=1 instead of set/clear.
module jk_excite
    import jk_bank_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] tgt,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

`ifdef JK_BANK_DRV_TOGGLE_EN
    localparam logic TGL_EN = 1'b1;
`else
    localparam logic TGL_EN = 1'b0;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        j = '0;
        k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            {j[i], k[i]} = excite_bit(q[i], tgt[i], TGL_EN);
        end
    end

endmodule

// File: rtl/jk_bank_driver.sv
// Write-side driver for a JK flip-flop bank: applies a target, reads q back, retries, reports.
// Optional macro JK_BANK_DRV_TOGGLE_EN (in jk_excite) selects toggle-style excitation.
module jk_bank_driver
    import jk_bank_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MAX_RETRY = 2,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    jk_bank_driver_if.slave    tgt,
    input  logic [WIDTH-1:0]   q_fb,
    output logic [WIDTH-1:0]   j,
    output logic [WIDTH-1:0]   k,
    output logic               done,
    output logic               err,
    output logic               err_sticky,
    output logic [CNT_W-1:0]   done_cnt,
    output logic [CNT_W-1:0]   err_cnt
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] tgt_q, tgt_nxt;
    logic [RW-1:0]    retry, retry_nxt;
    logic [WIDTH-1:0] exc_tgt, exc_j, exc_k;
    logic [WIDTH-1:0] j_nxt, k_nxt;
    logic             done_nxt, err_nxt;
    logic             match;

    // In IDLE the excitation targets the offered word; during retries, the latched one.
    assign exc_tgt = (state == IDLE) ? tgt.tgt_data : tgt_q;
    assign match   = (q_fb == tgt_q);

    assign tgt.tgt_ready = (state == IDLE);

    jk_excite #(.WIDTH(WIDTH)) u_excite (
        .q   (q_fb),
        .tgt (exc_tgt),
        .j   (exc_j),
        .k   (exc_k)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tgt.tgt_valid) state_nxt = APPLY;
            APPLY:   state_nxt = CHECK;
            CHECK: begin
                if (match)
                    state_nxt = IDLE;
                else if (retry < RETRY_LIM)
                    state_nxt = APPLY;
                else
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        j_nxt     = '0;
        k_nxt     = '0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        tgt_nxt   = tgt_q;
        retry_nxt = retry;
        case (state)
            IDLE: begin
                if (tgt.tgt_valid) begin
                    tgt_nxt   = tgt.tgt_data;
                    j_nxt     = exc_j;
                    k_nxt     = exc_k;
                    retry_nxt = '0;
                end
            end
            CHECK: begin
                if (match) begin
                    done_nxt = 1'b1;
                end else if (retry < RETRY_LIM) begin
                    retry_nxt = retry + RW'(1);
                    j_nxt     = exc_j;
                    k_nxt     = exc_k;
                end else begin
                    err_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and datapath; counters stop at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            j          <= '0;
            k          <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
            done_cnt   <= '0;
            err_cnt    <= '0;
            tgt_q      <= '0;
            retry      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            j          <= j_nxt;
            k          <= k_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
            err_sticky <= err_sticky | err_nxt;
            tgt_q      <= tgt_nxt;
            retry      <= retry_nxt;
            if (done_nxt && (done_cnt != '1))
                done_cnt <= done_cnt + CNT_W'(1);
            if (err_nxt && (err_cnt != '1))
                err_cnt <= err_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/jk_bank_driver.md
Name: jk_bank_driver

Overview:
- Write-side driver for a bank of WIDTH JK flip-flops sharing clk/rst with this block.
- Accepts a target state over a valid/ready handshake and applies the excitation table to produce per-bit j/k.
- Reads the bank's q back, checks it, and retries on mismatch up to a limit.
- Reports done or error pulses plus saturating event counters; the stimulus/control counterpart to the JK storage element.

Parameters:
- WIDTH, 4, number of JK flip-flops in the driven bank.
- MAX_RETRY, 2, re-applications allowed after a failed check before error (0 = no retry).
- CNT_W, 8, width of the done/error counters.

Ports:
- clk  in  1  clock; rising-edge.
- rst  in  1  asynchronous, active-high reset.
- tgt_valid  in  1  target word offered.
- tgt_ready  out  1  driver idle; accepts target.
- tgt_data  in  WIDTH  desired next bank state.
- q_fb  in  WIDTH  present q of the driven bank.
- j  out  WIDTH  J inputs to bank (registered).
- k  out  WIDTH  K inputs to bank (registered).
- done  out  1  one-cycle pulse: bank matched target.
- err  out  1  one-cycle pulse: retries exhausted.
- err_sticky  out  1  set by err, cleared only by rst.
- done_cnt  out  CNT_W  saturating count of done pulses.
- err_cnt  out  CNT_W  saturating count of err pulses.

Behaviour:
- Reset (async, immediate): state IDLE; j=k=0; done=err=err_sticky=0; counters 0; retry counter 0; target register 0. Bank is reset to 0 by the same rst.
- Per-bit excitation (default, don't-cares resolved to 0):
  - q 0->0: J=0, K=0.
  - q 0->1: J=1, K=0.
  - q 1->0: J=0, K=1.
  - q 1->1: J=0, K=0.
- FSM, IDLE/APPLY/CHECK, all transitions on rising clk:
  - IDLE: tgt_ready=1; j=k=0, so the bank holds. On tgt_valid: latch tgt_data, load j/k = excite(q_fb, tgt_data), clear retry count, go APPLY.
  - APPLY: one cycle; j/k stable. The bank updates at the closing edge. Driver loads j=k=0 and goes CHECK.
  - CHECK: compare q_fb with the latched target.
    - Match: go IDLE, done=1 next cycle, done_cnt++.
    - Mismatch with retry<MAX_RETRY: retry++, reload j/k = excite(q_fb, target), go APPLY.
    - Mismatch with retry==MAX_RETRY: go IDLE, err=1 next cycle, err_sticky=1, err_cnt++.
- Latency: acceptance edge E0 -> APPLY cycle -> bank updates at E1 -> CHECK cycle -> done high in the cycle after E2, coincident with tgt_ready=1. Back-to-back acceptance is allowed in that cycle.
- tgt_ready is low in APPLY and CHECK. A valid held during busy is not lost; it is accepted on return to IDLE.
- Target equal to current q: j=k=0, still takes APPLY+CHECK, then done.
- Counters saturate at all-ones; no wrap.
- done and err are never high together. err_sticky does not block operation.
- Reset mid-APPLY/CHECK: outputs to reset values at once, no done/err pulse, transaction dropped.

Optional Feature:
- Macro: JK_BANK_DRV_TOGGLE_EN.
- Defined: every bit needing a change is driven J=K=1 (toggle); bits that hold keep J=K=0. This exercises the bank's toggle path.
- Undefined: the default excitation above; the toggle condition is never driven.
- Handshake, timing and counters are identical either way.

Decomposition:
- Package jk_bank_pkg: FSM state enum (IDLE, APPLY, CHECK); per-bit excitation encoding constants; default WIDTH/CNT_W.
- Sub-module jk_excite: combinational WIDTH-wide excitation from (q, target) to (j, k); holds the TOGGLE_EN selection.
- Top jk_bank_driver holds the FSM, target/retry registers and counters.

Test Plan:
- Reset then idle, bank q=0000 -> j=k=0000, tgt_ready=1, done_cnt=err_cnt=0, err_sticky=0.
- Target 1010 from q=0000 -> APPLY shows j=1010, k=0000; q=1010 at E1; done pulse the cycle after E2; done_cnt=1.
- Target 0101 from q=1010 (default) -> j=0101, k=1010; done; done_cnt=2. Same with JK_BANK_DRV_TOGGLE_EN -> j=k=1111.
- Bench forces q_fb bit0 stuck at 0, target 0001, MAX_RETRY=2 -> three APPLY cycles, err pulse, err_sticky=1, err_cnt=1, no done.
- tgt_valid held high across two targets -> second target accepted exactly in the cycle done is high; tgt_ready low in APPLY/CHECK.
- rst asserted mid-APPLY -> j=k=0 immediately, tgt_ready=1 after release, no done/err, counters 0.
